stswi_debounce: RTL

Input conditioner between the board slide switches (stswi) and the logic that consumes them, such as the adder datapaths and LED drivers. Each raw, asynchronous, bouncy switch line is synchronized into the clk domain and debounced by a stability counter. The block then presents a clean level per switch, plus single-cycle rise and fall event pulses. It is the producing end of the switch interface that downstream stled-driving blocks read.

---
 rtl/stswi_debounce_pkg.sv | 41 ++++
 rtl/stswi_debounce_bit.sv | 80 ++++++++
 rtl/stswi_debounce.sv | 42 ++++
 3 files changed

// File: rtl/stswi_debounce_pkg.sv
// Shared constants and helpers for the slide-switch conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control; switch events are fire-and-forget).
package stswi_debounce_pkg;

    // 1 ms of stability at the 50 MHz board clock.
    localparam int CNT_MAX_BOARD   = 50000;
    // Short stability window so simulations finish quickly.
    localparam int CNT_MAX_SIM     = 4;
    // Default synchronizer depth and line count.
    localparam int SYNC_STAGES_DEF = 2;
    localparam int NUM_SW_DEF      = 2;

    // Per-line conditioned outputs, bundled so the top can fan them out.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } sw_evt_t;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Stability counter width: enough to hold CNT_MAX-1, never below 1 bit.
    function automatic int cnt_width(input int cnt_max);
        int w;
        w = clog2(cnt_max);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stswi_debounce_bit.sv
// Single-line switch conditioner: synchronizer, stability counter, level and edge pulses.
// Latency: SYNC_STAGES + CNT_MAX edges from first sampling edge to new level/pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module stswi_debounce_bit
    import stswi_debounce_pkg::*;
#(
    parameter int CNT_MAX     = CNT_MAX_BOARD,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    sw_raw,
    output sw_evt_t sw_evt
);

    localparam int            CW       = cnt_width(CNT_MAX);
    // Count value on which a still-differing input is accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] syn_q;
    logic [SYNC_STAGES-1:0] syn_d;
    logic                   syn;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Plain shift chain; nothing but flops sits ahead of the last stage.
    always_comb begin
        syn_d = {syn_q[SYNC_STAGES-2:0], sw_raw};
    end

    assign syn = syn_q[SYNC_STAGES-1];

    // Stability counter: runs only while the synchronized input disagrees
    // with the accepted level; any agreeing cycle drops back to zero, which
    // is how glitches shorter than CNT_MAX are discarded without a pulse.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (syn != level_q) begin
            if (cnt_q == CNT_LAST) begin
                // Accept: new level and its edge pulse land on the same edge.
                level_d = syn;
                rise_d  = syn;
                fall_d  = ~syn;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State and registered outputs; everything clears at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_q   <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            syn_q   <= syn_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_evt.level = level_q;
    assign sw_evt.rise  = rise_q;
    assign sw_evt.fall  = fall_q;

endmodule

// File: rtl/stswi_debounce.sv
// Slide-switch conditioner: NUM_SW independent debounced lines plus an any-event flag.
// Latency: SYNC_STAGES + CNT_MAX edges from first sampling edge to level/pulse.
// Backpressure: none; rise/fall/any are single-cycle pulses, level is a steady output.
module stswi_debounce
    import stswi_debounce_pkg::*;
#(
    parameter int NUM_SW      = NUM_SW_DEF,
    parameter int CNT_MAX     = CNT_MAX_BOARD,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] stswi,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              sw_any
);

    sw_evt_t line_evt [NUM_SW];

    // One fully independent conditioner per switch line.
    for (genvar i = 0; i < NUM_SW; i++) begin : g_line
        stswi_debounce_bit #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_raw (stswi[i]),
            .sw_evt (line_evt[i])
        );

        assign sw_level[i] = line_evt[i].level;
        assign sw_rise[i]  = line_evt[i].rise;
        assign sw_fall[i]  = line_evt[i].fall;
    end

    // OR of registered pulses, so it is aligned with them and glitch-free.
    assign sw_any = |(sw_rise | sw_fall);

endmodule
